// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the single-cycle controller.
// Owns the PC, fetches one instruction over a valid/ready memory port,
// holds it stable for the datapath and advances on consume.
// Optional build macro FETCH_CNT_EN adds a 32-bit consume counter output.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | post-reset bubble, nothing outstanding
// REQ   | request valid, imem_addr = PC held until accepted
// WAIT  | request accepted, waiting for read data
// HOLD  | instruction valid for the datapath until consumed
// ERR   | misaligned branch/jump target taken; sticky until reset
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [6:0]      OPcode,
    output logic [2:0]      Funct3,
    output logic [6:0]      Funct7,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            fetch_err
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0]     fetch_count
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [31:0]     NOP    = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc_q + PC_INC;

`ifdef FETCH_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    assign fetch_count = cnt_q;
`endif

    // State, PC and instruction registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
`ifdef FETCH_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef FETCH_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state logic; inputs are only qualified in the state that uses them.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_CNT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
`ifdef FETCH_CNT_EN
                    cnt_d = cnt_q + 32'd1;
`endif
                    if (PCSrc) begin
                        // A misaligned target leaves PC pointing at the faulting instruction.
                        if (PCTarget[1:0] != 2'b00) begin
                            state_d = ERR;
                        end else begin
                            pc_d    = PCTarget;
                            state_d = REQ;
                        end
                    end else begin
                        pc_d    = pc_plus4;
                        state_d = REQ;
                    end
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from state; fields split combinationally from instr.
    always_comb begin
        imem_req_valid = (state_q == REQ);
        instr_valid    = (state_q == HOLD);
        fetch_err      = (state_q == ERR);
        imem_addr      = pc_q;
        PC             = pc_q;
        PCPlus4        = pc_plus4;
        instr          = instr_q;
        OPcode         = instr_q[6:0];
        Funct3         = instr_q[14:12];
        Funct7         = instr_q[31:25];
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  OPcode;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        fetch_err;
`ifdef FETCH_CNT_EN
    logic [31:0] fetch_count;
`endif

    int checks = 0;
    int errors = 0;
    int unsigned cnt_exp = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .OPcode         (OPcode),
        .Funct3         (Funct3),
        .Funct7         (Funct7),
        .PC             (PC),
        .PCPlus4        (PCPlus4),
        .PCSrc          (PCSrc),
        .PCTarget       (PCTarget),
        .fetch_err      (fetch_err)
`ifdef FETCH_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rdata     = 32'h0;
        instr_ready    = 1'b0;
        PCSrc          = 1'b0;
        PCTarget       = 32'h0;
        tick();
        tick();
        reset   = 1'b0;
        cnt_exp = 0;
    endtask

    task automatic step_handshake();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
    endtask

    task automatic step_response(input logic [31:0] data);
        imem_rsp_valid = 1'b1;
        imem_rdata     = data;
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic step_consume(input logic src, input logic [31:0] tgt);
        instr_ready = 1'b1;
        PCSrc       = src;
        PCTarget    = tgt;
        tick();
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        PCTarget    = 32'h0;
        cnt_exp     = cnt_exp + 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req_valid); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_ivalid got %b exp 0", instr_valid); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", fetch_err); end
        checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL rst_instr got %h exp 00000013", instr); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", PC); end
`ifdef FETCH_CNT_EN
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", fetch_count); end
`endif
    endtask

    task automatic test_first_fetch();
        tick();
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got v=%b a=%h exp v=1 a=0", imem_req_valid, imem_addr); end
        step_handshake();
        checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL first_wait got rv=%b iv=%b exp 0 0", imem_req_valid, instr_valid); end
        step_response(32'h0050_0093);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093) begin errors++; $display("FAIL first_hold got iv=%b i=%h exp 1 00500093", instr_valid, instr); end
        checks++; if (OPcode !== 7'b0010011 || Funct3 !== 3'd0 || Funct7 !== 7'd0) begin errors++; $display("FAIL first_fields got %b %b %b exp 0010011 000 0000000", OPcode, Funct3, Funct7); end
        checks++; if (PCPlus4 !== 32'h4 || PC !== 32'h0) begin errors++; $display("FAIL first_pc got pc=%h p4=%h exp 0 4", PC, PCPlus4); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        for (int i = 1; i <= 3; i++) begin
            exp_addr = 32'(4 * i);
            step_consume(1'b0, 32'hFFFF_FFF0);
            checks++; if (imem_req_valid !== 1'b1 || imem_addr !== exp_addr || instr_valid !== 1'b0) begin errors++; $display("FAIL seq_addr%0d got v=%b a=%h exp v=1 a=%h", i, imem_req_valid, imem_addr, exp_addr); end
            step_handshake();
            step_response(32'h0000_0013 + 32'(i << 7));
        end
        checks++; if (PC !== 32'hC || instr !== 32'h0000_0193) begin errors++; $display("FAIL seq_end got pc=%h i=%h exp c 00000193", PC, instr); end
    endtask

    task automatic test_branch();
        step_consume(1'b1, 32'h40);
        checks++; if (imem_addr !== 32'h40 || PC !== 32'h40 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL branch_addr got a=%h pc=%h v=%b exp 40 40 1", imem_addr, PC, imem_req_valid); end
        step_handshake();
        step_response(32'h0000_0013);
        checks++; if (instr_valid !== 1'b1 || PCPlus4 !== 32'h44) begin errors++; $display("FAIL branch_hold got iv=%b p4=%h exp 1 44", instr_valid, PCPlus4); end
    endtask

    task automatic test_stall();
        step_consume(1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                imem_rsp_valid = 1'b1;
                imem_rdata     = 32'hDEAD_BEEF;
            end
            checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h44 || instr_valid !== 1'b0) begin errors++; $display("FAIL stall_req%0d got v=%b a=%h iv=%b exp 1 44 0", i, imem_req_valid, imem_addr, instr_valid); end
            tick();
            imem_rsp_valid = 1'b0;
        end
        step_handshake();
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin errors++; $display("FAIL stall_wait%0d got rv=%b iv=%b i=%h exp 0 0 00000013", i, imem_req_valid, instr_valid, instr); end
            tick();
        end
        step_response(32'h4020_D133);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h4020_D133) begin errors++; $display("FAIL stall_cap got iv=%b i=%h exp 1 4020d133", instr_valid, instr); end
        checks++; if (OPcode !== 7'h33 || Funct3 !== 3'b101 || Funct7 !== 7'h20) begin errors++; $display("FAIL stall_fields got %h %b %h exp 33 101 20", OPcode, Funct3, Funct7); end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 6; i++) begin
            imem_rsp_valid = (i == 3);
            imem_rdata     = 32'hCAFE_F00D;
            imem_req_ready = 1'b1;
            tick();
            imem_rsp_valid = 1'b0;
            imem_req_ready = 1'b0;
            checks++; if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0 || instr !== 32'h4020_D133 || PC !== 32'h44) begin errors++; $display("FAIL bp_hold%0d got iv=%b rv=%b i=%h pc=%h exp 1 0 4020d133 44", i, instr_valid, imem_req_valid, instr, PC); end
        end
    endtask

    task automatic test_misaligned();
        step_consume(1'b1, 32'h42);
        for (int i = 0; i < 4; i++) begin
            checks++; if (fetch_err !== 1'b1 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || PC !== 32'h44) begin errors++; $display("FAIL err_state%0d got e=%b rv=%b iv=%b pc=%h exp 1 0 0 44", i, fetch_err, imem_req_valid, instr_valid, PC); end
            instr_ready    = 1'b1;
            imem_req_ready = 1'b1;
            tick();
            instr_ready    = 1'b0;
            imem_req_ready = 1'b0;
        end
`ifdef FETCH_CNT_EN
        checks++; if (fetch_count !== 32'(cnt_exp)) begin errors++; $display("FAIL err_cnt got %0d exp %0d", fetch_count, cnt_exp); end
`endif
        do_reset();
        checks++; if (fetch_err !== 1'b0 || PC !== 32'h0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL err_reset got e=%b pc=%h rv=%b exp 0 0 0", fetch_err, PC, imem_req_valid); end
`ifdef FETCH_CNT_EN
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL err_cnt_rst got %0d exp 0", fetch_count); end
`endif
    endtask

    task automatic test_reset_mid_wait();
        tick();
        step_handshake();
        reset          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'h1234_5678;
        tick();
        reset = 1'b0;
        tick();
        imem_rsp_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || instr !== 32'h0000_0013 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid got iv=%b i=%h rv=%b a=%h exp 0 00000013 1 0", instr_valid, instr, imem_req_valid, imem_addr); end
    endtask

    task automatic test_wrap();
        step_handshake();
        step_response(32'h0000_0013);
        step_consume(1'b1, 32'hFFFF_FFFC);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_tgt got %h exp fffffffc", imem_addr); end
        step_handshake();
        step_response(32'h0000_0013);
        checks++; if (PCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_p4 got %h exp 0", PCPlus4); end
        step_consume(1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h0 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL wrap_addr got a=%h v=%b exp 0 1", imem_addr, imem_req_valid); end
`ifdef FETCH_CNT_EN
        checks++; if (fetch_count !== 32'(cnt_exp)) begin errors++; $display("FAIL wrap_cnt got %0d exp %0d", fetch_count, cnt_exp); end
`endif
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branch();
        test_stall();
        test_back_pressure();
        test_misaligned();
        test_reset_mid_wait();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle controller/datapath.
- Owns the PC and fetches one 32-bit instruction at a time over a valid/ready instruction-memory interface.
- Holds the instruction stable and splits it into OPcode/Funct3/Funct7 for the controller.
- On consume, advances the PC to PC+4, or to PCTarget when the controller's PCSrc is high.

Parameters:
- XLEN, 32, width of PC and addresses.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  XLEN  fetch address (equals PC).
- imem_rsp_valid  input  1  read data valid.
- imem_rdata  input  32  read data.
- instr_valid  output  1  instr/fields valid for the datapath.
- instr_ready  input  1  datapath consumes the current instruction this cycle.
- instr  output  32  latched instruction.
- OPcode  output  7  instr[6:0].
- Funct3  output  3  instr[14:12].
- Funct7  output  7  instr[31:25].
- PC  output  XLEN  address of the held instruction.
- PCPlus4  output  XLEN  PC+4, modulo 2^XLEN.
- PCSrc  input  1  take PCTarget on consume.
- PCTarget  input  XLEN  branch/jump target.
- fetch_err  output  1  sticky misaligned-target error.

Behaviour:
- Reset (sync, active-high): PC=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req_valid=0, fetch_err=0, state=IDLE.
  - Reset has priority over every other event.
  - Reset mid-request or mid-wait abandons the transaction. Late rsp_valid is ignored because state is IDLE.
- FSM states and transitions:
  - IDLE: outputs idle; always -> REQ next cycle.
  - REQ: imem_req_valid=1, imem_addr=PC held stable; -> WAIT on the cycle imem_req_ready=1.
  - WAIT: imem_req_valid=0. On imem_rsp_valid=1, capture imem_rdata into instr and -> HOLD.
  - HOLD: instr_valid=1; instr, fields and PC stable. On instr_ready=1, see PC update below.
  - ERR: instr_valid=0, imem_req_valid=0, fetch_err=1; exits only on reset.
- PC update on consume (HOLD with instr_ready=1):
  - Next PC = PCSrc ? PCTarget : PC+4; -> REQ.
  - If PCSrc=1 and PCTarget[1:0]!=0: PC unchanged, -> ERR.
- Input qualification:
  - imem_rsp_valid outside WAIT is ignored.
  - instr_ready outside HOLD is ignored.
  - PCSrc/PCTarget are sampled only on the consume edge.
- Latency:
  - Request handshake at edge N -> WAIT.
  - rsp_valid sampled at edge M>N -> instr_valid high from cycle M+1.
  - Consume at edge K -> imem_req_valid high in cycle K+1.
  - Minimum steady-state: 3 cycles per instruction with zero-wait memory.
- OPcode/Funct3/Funct7/PCPlus4 are purely combinational from instr/PC.
- Arithmetic: PC+4 wraps, e.g. 32'hFFFF_FFFC -> 32'h0000_0000.
- Back-pressure: instr_ready low holds HOLD indefinitely, with no further memory requests.

Optional Feature:
- Macro: FETCH_CNT_EN.
- Defined:
  - Adds output fetch_count [31:0], reset to 0.
  - Increments by 1 on each HOLD consume edge, including one that goes to ERR.
  - Wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory returning 32'h00500093 -> imem_addr=0; instr_valid by cycle 3; OPcode=7'b0010011, Funct3=0, Funct7=0; PCPlus4=4.
- Consume with PCSrc=0 three times -> imem_addr sequence 0,4,8,12.
- Consume with PCSrc=1, PCTarget=32'h40 -> next imem_addr=32'h40, PC=32'h40.
- imem_req_ready low 5 cycles, then rsp_valid delayed 4 cycles -> imem_addr stable throughout; rsp_valid pulse while in REQ ignored; instr_valid only after the WAIT capture.
- PCSrc=1, PCTarget=32'h42 -> fetch_err=1, no further requests; reset clears fetch_err and PC returns to RESET_PC.
- PC=32'hFFFF_FFFC consume with PCSrc=0 -> next imem_addr=0. With FETCH_CNT_EN, fetch_count counts consumes.
